// File: rtl/serial_sort_ctrl.sv
// serial_sort_ctrl: loads a DEPTH-word frame, bubble-sorts it in place with
// one shared comparator, then drains it. Define SERIAL_SORT_DESCEND_EN for descending order.
module serial_sort_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    OUT
  } state_t;

  state_t state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] cmp_idx;
  logic [IW-1:0] nxt_idx;
  logic [IW-1:0] pass;
  logic [IW-1:0] last_idx;
  logic swapped;
  logic ready_q;
  logic busy_q;
  logic valid_q;

  logic [WIDTH-1:0] lo_w;
  logic [WIDTH-1:0] hi_w;
  logic swap_now;
  logic pass_end;
  logic done;
  logic in_fire;
  logic out_fire;

  assign nxt_idx  = cmp_idx + 1'b1;
  assign last_idx = IW'(DEPTH - 2) - pass;
  assign lo_w     = mem[cmp_idx];
  assign hi_w     = mem[nxt_idx];

`ifdef SERIAL_SORT_DESCEND_EN
  assign swap_now = (state == SORT) && !rst && (lo_w < hi_w);
`else
  assign swap_now = (state == SORT) && !rst && (lo_w > hi_w);
`endif

  assign pass_end = (cmp_idx == last_idx);
  assign done     = !(swapped || swap_now)
                    || (pass == IW'(DEPTH - 2));

  // Outputs are registered flags, forced low while reset is held.
  assign in_ready  = ready_q & ~rst;
  assign busy      = busy_q & ~rst;
  assign out_valid = valid_q & ~rst;
  assign out_data  = out_valid ? mem[rd_idx] : '0;
  assign out_last  = out_valid && (rd_idx == IW'(DEPTH - 1));

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Frame sequencing: load, bubble-sort passes with early exit, drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      wr_idx  <= '0;
      rd_idx  <= '0;
      pass    <= '0;
      cmp_idx <= '0;
      swapped <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_fire) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == IW'(DEPTH - 1)) begin
              state   <= SORT;
              cmp_idx <= '0;
              pass    <= '0;
              swapped <= 1'b0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        SORT: begin
          if (pass_end) begin
            if (done) begin
              state   <= OUT;
              rd_idx  <= '0;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              pass    <= pass + 1'b1;
              cmp_idx <= '0;
              swapped <= 1'b0;
            end
          end else begin
            cmp_idx <= nxt_idx;
            swapped <= swapped | swap_now;
          end
        end
        OUT: begin
          if (out_fire) begin
            if (rd_idx == IW'(DEPTH - 1)) begin
              state   <= LOAD;
              wr_idx  <= '0;
              rd_idx  <= '0;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Register file: written by the input stream or by a compare-and-swap.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_idx] <= in_data;
    end else if (swap_now) begin
      mem[cmp_idx] <= hi_w;
      mem[nxt_idx] <= lo_w;
    end
  end

endmodule
